multi_down_counter: RTL and testbench
=====================================

Name: multi_down_counter

Overview:
Parametrised, multi-channel successor to the team's single 4-bit loadable down-counter. Each channel holds a WIDTH-bit count that is loaded, decremented, and flagged at zero. Each channel adds optional periodic auto-reload, a one-cycle terminal-count pulse and a sticky expired flag. Used as the general timer/event-count resource; channels are fully independent.

Parameters:
WIDTH, 8, bits per channel count (>=2)
CHANNELS, 4, number of independent channels (>=1)

Ports:
clock  in  1  rising-edge clock for all state
reset_n  in  1  asynchronous, active-low reset
latch  in  CHANNELS  per-channel load strobe
in  in  CHANNELS*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH]
dec  in  CHANNELS  per-channel decrement enable
periodic  in  CHANNELS  per-channel mode: 1 = auto-reload at zero, 0 = one-shot
clr  in  CHANNELS  per-channel clear of sticky expired flag
count  out  CHANNELS*WIDTH  current count values, registered
zero  out  CHANNELS  per-channel count==0, combinational from count
tc  out  CHANNELS  registered one-cycle pulse when a channel reaches 0 by decrement
expired  out  CHANNELS  sticky per-channel flag, set by tc condition, cleared by clr
any_zero  out  1  OR of zero

Behaviour:
- Reset: reset_n low acts immediately, without a clock edge.
  - count=0, reload register=0, tc=0, expired=0.
  - Therefore zero=all ones and any_zero=1.
- Per channel i, at each rising clock edge, priority order:
  1. latch[i]=1:
     - count <= in slice; reload <= in slice.
     - tc <= 0. dec[i] is ignored this cycle.
  2. dec[i]=1 and count!=0:
     - count <= count-1.
     - If count==1: tc <= 1 (asserted in the same cycle count shows 0).
  3. dec[i]=1, count==0, periodic[i]=1, reload!=0:
     - count <= reload; tc <= 0.
  4. All other cases: count holds; tc <= 0.
     - Includes one-shot at zero and periodic with reload==0.
- Periodic period: exactly reload+1 dec cycles between successive tc pulses when dec is held high.
- No wrap-around: a decrement never takes 0 to 2^WIDTH-1.
- Arithmetic is WIDTH-bit unsigned; the reload register is WIDTH bits.
- Changing periodic[i] takes effect on the next edge at which the channel is at zero. It does not alter the reload register.
- expired[i]:
  - Set on the edge where tc[i] is set.
  - Cleared on an edge with clr[i]=1.
  - Simultaneous set and clr: set wins.
  - Not affected by latch.
- Load latency: a loaded value appears on count one edge after latch is sampled high.
- Decrement latency: one edge.
- zero, any_zero: purely combinational from registered count; no extra latency.
- Loading 0: zero asserts next cycle; tc is not pulsed and expired is not set.
- Loading while the channel is counting restarts it; any pending periodic state is replaced.
- Reset mid-operation: all state returns to reset values immediately. The first edge after reset_n rises behaves as from the reset state.
- Channels share no state; simultaneous activity on all channels is legal.

Test Plan:
- Reset, then WIDTH=8, CH0: latch in=2, then dec held 1 -> count 2,1,0. tc pulses only in the cycle count==0. zero=1 from then on; count holds at 0 (one-shot); expired=1.
- CH1 periodic=1, latch in=3, dec held 1 for 12 cycles -> count 3,2,1,0,3,2,1,0,3... with tc every 4th cycle. Set clr alongside a tc edge -> expired stays 1.
- CH2: latch and dec both high with in=5 -> count=5, no decrement. Then latch in=0 -> zero=1, tc=0, expired unchanged.
- CH3 periodic=1 with reload 0, dec high -> count stays 0; tc and expired never assert. any_zero stays 1 while any channel is at 0.
- All channels loaded 0xFF and decrementing; pull reset_n low mid-count between edges -> count=0, tc=0, expired=0 immediately. After release, dec at count 0 does not wrap to 0xFF.

Source files
------------

// File: rtl/multi_down_counter.sv
// Multi-channel loadable down-counter with periodic auto-reload,
// terminal-count pulse and sticky expired flag per channel.
module multi_down_counter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       latch,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       expired,
  output logic                      any_zero
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] ld;
    logic             tc_q;
    logic             exp_q;
    logic             at_zero;
    logic             do_dec;
    logic             do_rld;
    logic             hit;

    assign ld      = in[i*WIDTH +: WIDTH];
    assign at_zero = (cnt == '0);
    assign do_dec  = dec[i] && !at_zero;
    assign do_rld  = dec[i] && at_zero
                     && periodic[i] && (rld != '0);
    // Terminal count only from a real decrement, never from a load
    assign hit     = !latch[i] && do_dec
                     && (cnt == WIDTH'(1));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt  <= '0;
        rld  <= '0;
        tc_q <= 1'b0;
      end else begin
        priority case (1'b1)
          latch[i]: begin
            cnt  <= ld;
            rld  <= ld;
            tc_q <= 1'b0;
          end
          do_dec: begin
            cnt  <= cnt - WIDTH'(1);
            tc_q <= hit;
          end
          do_rld: begin
            cnt  <= rld;
            tc_q <= 1'b0;
          end
          default: tc_q <= 1'b0;
        endcase
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    exp_q <= 1'b0;
      else if (hit)    exp_q <= 1'b1;
      else if (clr[i]) exp_q <= 1'b0;
    end

    assign count[i*WIDTH +: WIDTH] = cnt;
    assign zero[i]                 = at_zero;
    assign tc[i]                   = tc_q;
    assign expired[i]              = exp_q;
  end

  assign any_zero = |zero;

endmodule

// File: tb/tb_multi_down_counter.sv
// Scoreboard bench for multi_down_counter: directed plan
// followed by randomized traffic against a behavioural model.
module tb_multi_down_counter;
  localparam int W  = 8;
  localparam int CH = 4;

  typedef struct packed {
    logic [CH*W-1:0] count;
    logic [CH-1:0]   tc;
    logic [CH-1:0]   expired;
    logic [CH-1:0]   zero;
    logic            any_zero;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [CH-1:0]   latch = '0;
  logic [CH*W-1:0] din = '0;
  logic [CH-1:0]   dec = '0;
  logic [CH-1:0]   periodic = '0;
  logic [CH-1:0]   clr = '0;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   zero;
  logic [CH-1:0]   tc;
  logic [CH-1:0]   expired;
  logic            any_zero;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];

  int m_cnt [CH];
  int m_rld [CH];
  bit m_tc  [CH];
  bit m_exp [CH];

  multi_down_counter #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .latch    (latch),
    .in       (din),
    .dec      (dec),
    .periodic (periodic),
    .clr      (clr),
    .count    (count),
    .zero     (zero),
    .tc       (tc),
    .expired  (expired),
    .any_zero (any_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0;
      m_rld[i] = 0;
      m_tc[i]  = 0;
      m_exp[i] = 0;
    end
  endfunction

  // Next state from the channel rules, using currently driven inputs
  function automatic void model_step();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      int v;
      v = int'(din[i*W +: W]);
      if (latch[i]) begin
        m_cnt[i] = v;
        m_rld[i] = v;
        m_tc[i]  = 0;
      end else if (dec[i] && m_cnt[i] > 0) begin
        m_tc[i]  = (m_cnt[i] == 1);
        m_cnt[i] = m_cnt[i] - 1;
      end else if (dec[i] && periodic[i] && m_rld[i] > 0) begin
        m_cnt[i] = m_rld[i];
        m_tc[i]  = 0;
      end else begin
        m_tc[i] = 0;
      end
      if (m_tc[i])     m_exp[i] = 1;
      else if (clr[i]) m_exp[i] = 0;
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      e.count[i*W +: W] = m_cnt[i][W-1:0];
      e.tc[i]           = m_tc[i];
      e.expired[i]      = m_exp[i];
      e.zero[i]         = (m_cnt[i] == 0);
    end
    e.any_zero = |e.zero;
    return e;
  endfunction

  task automatic step(input logic [CH-1:0] l, input logic [CH*W-1:0] v,
                      input logic [CH-1:0] d, input logic [CH-1:0] p,
                      input logic [CH-1:0] c);
    @(negedge clock);
    latch = l; din = v; dec = d; periodic = p; clr = c;
    model_step();
    sb.push_back(snap());
  endtask

  task automatic idle_inputs();
    latch = '0; din = '0; dec = '0; periodic = '0; clr = '0;
  endtask

  // Monitor: pops one expectation after every edge that has one
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count",    32'(count),    32'(e.count));
        chk("tc",       32'(tc),       32'(e.tc));
        chk("expired",  32'(expired),  32'(e.expired));
        chk("zero",     32'(zero),     32'(e.zero));
        chk("any_zero", 32'(any_zero), 32'(e.any_zero));
      end
    end
  end

  initial begin
    logic [CH-1:0]   l, d, c;
    logic [CH-1:0]   p;
    logic [CH*W-1:0] v;
    model_reset();
    #2;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_tc",       32'(tc),       32'd0);
    chk("rst_expired",  32'(expired),  32'd0);
    chk("rst_zero",     32'(zero),     32'hF);
    chk("rst_any_zero", 32'(any_zero), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;

    // CH0 one-shot from 2
    step(4'b0001, 32'h0000_0002, 4'b0000, 4'b0000, 4'b0000);
    repeat (5) step(4'b0000, '0, 4'b0001, 4'b0000, 4'b0000);

    // CH1 periodic reload 3, clr held so it coincides with tc edges
    step(4'b0010, 32'h0000_0300, 4'b0000, 4'b0010, 4'b0000);
    repeat (12) step(4'b0000, '0, 4'b0010, 4'b0010, 4'b0010);
    repeat (3) step(4'b0000, '0, 4'b0010, 4'b0010, 4'b0000);

    // CH2 latch beats dec, then load 0
    step(4'b0100, 32'h0005_0000, 4'b0100, 4'b0000, 4'b0000);
    step(4'b0000, '0, 4'b0100, 4'b0000, 4'b0000);
    step(4'b0100, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, '0, 4'b0100, 4'b0000, 4'b0000);

    // CH3 periodic with reload 0
    step(4'b1000, 32'h0000_0000, 4'b0000, 4'b1000, 4'b0000);
    repeat (4) step(4'b0000, '0, 4'b1000, 4'b1000, 4'b0000);

    // All channels from 0xFF, then async reset between edges
    step(4'b1111, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 4'b0000);
    repeat (3) step(4'b0000, '0, 4'b1111, 4'b0000, 4'b0000);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_count",   32'(count),    32'd0);
    chk("mid_rst_tc",      32'(tc),       32'd0);
    chk("mid_rst_expired", 32'(expired),  32'd0);
    chk("mid_rst_zero",    32'(zero),     32'hF);
    chk("mid_rst_anyzero", 32'(any_zero), 32'd1);
    repeat (2) step(4'b1111, 32'hFFFF_FFFF, 4'b1111, 4'b1111, 4'b0000);
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
    repeat (3) step(4'b0000, '0, 4'b1111, 4'b1111, 4'b0000);

    // Randomized traffic
    p = '0;
    for (int n = 0; n < 400; n++) begin
      l = '0; d = '0; c = '0; v = '0;
      for (int i = 0; i < CH; i++) begin
        int r;
        l[i] = ($urandom_range(0, 9) == 0);
        d[i] = ($urandom_range(0, 3) != 0);
        c[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) p[i] = ~p[i];
        r = $urandom_range(0, 3);
        if (r == 0)      v[i*W +: W] = '0;
        else if (r == 1) v[i*W +: W] = W'($urandom_range(1, 4));
        else             v[i*W +: W] = W'($urandom_range(0, 255));
      end
      step(l, v, d, p, c);
    end

    @(negedge clock);
    idle_inputs();
    repeat (3) @(negedge clock);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
